// File: rtl/musa_trace_buffer_if.sv
// Probe capture and readout handshake bundle for musa_trace_buffer.
// The master side feeds samples and requests reads; the buffer is the slave.
interface musa_trace_buffer_if #(
    parameter int PROBE_WIDTH = 32
);
    logic                   probe_valid;
    logic [PROBE_WIDTH-1:0] probe_data;
    logic                   rd_en;
    logic [PROBE_WIDTH-1:0] rd_data;
    logic                   rd_valid;

    modport master (
        output probe_valid, probe_data, rd_en,
        input  rd_data, rd_valid
    );

    modport slave (
        input  probe_valid, probe_data, rd_en,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/musa_trace_buffer.sv
// Circular trace capture for MUSA probe signals: trigger/post-window or one-shot fill,
// followed by an oldest-first drain with one-cycle read latency.
module musa_trace_buffer #(
    parameter int  PROBE_WIDTH = 32,
    parameter int  DEPTH       = 64,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    musa_trace_buffer_if.slave     bus,
    input  logic                   arm,
    input  logic                   mode,
    input  logic [PROBE_WIDTH-1:0] trig_value,
    input  logic [PROBE_WIDTH-1:0] trig_mask,
    input  logic                   ext_trig,
    input  logic [AW-1:0]          post_count,
    output logic [1:0]             state,
    output logic [AW:0]            count,
    output logic [AW-1:0]          trig_index,
    output logic                   triggered
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_POST  = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_COUNT = (AW+1)'(DEPTH - 1);

    state_t                 state_reg, state_next;
    logic [PROBE_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr_reg;
    logic [AW:0]            count_reg;
    logic [AW-1:0]          post_cnt_reg;
    logic [AW-1:0]          post_written_reg;
    logic [AW-1:0]          post_count_reg;
    logic                   mode_reg;
    logic                   triggered_reg;
    logic [AW-1:0]          trig_index_reg;
    logic [PROBE_WIDTH-1:0] rd_data_reg;
    logic                   rd_valid_reg;

    logic                   do_write, do_read, do_arm, enter_done, trig_hit, mask_match;
    logic [AW:0]            count_inc;
    logic [AW-1:0]          post_written_inc;
    logic [AW-1:0]          rd_addr;
    logic [PROBE_WIDTH-1:0] bit_match;

    // Per-bit masked compare; an all-zero mask disables the value match entirely.
    genvar gi;
    generate
        for (gi = 0; gi < PROBE_WIDTH; gi++) begin : g_match
            assign bit_match[gi] = !trig_mask[gi] || (bus.probe_data[gi] == trig_value[gi]);
        end
    endgenerate

    assign mask_match = (|trig_mask) && (&bit_match);
    assign trig_hit   = bus.probe_valid && (ext_trig || mask_match);

    assign count_inc        = (count_reg == FULL_COUNT) ? count_reg : count_reg + 1'b1;
    assign post_written_inc = post_written_reg + AW'(state_reg == S_POST);
    assign rd_addr          = wr_ptr_reg - count_reg[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (arm) state_next = S_ARMED;
            S_ARMED: begin
                if (bus.probe_valid) begin
                    if (mode_reg) begin
                        if (count_reg == LAST_COUNT) state_next = S_DONE;
                    end else if (trig_hit) begin
                        state_next = (post_count_reg == '0) ? S_DONE : S_POST;
                    end
                end
            end
            S_POST:  if (bus.probe_valid && post_cnt_reg == AW'(1)) state_next = S_DONE;
            S_DONE: begin
                if (arm) state_next = S_ARMED;
                else if (bus.rd_en && count_reg == (AW+1)'(1)) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Arm wins over a same-cycle read in DONE, so that read is dropped.
    always_comb begin
        do_write   = bus.probe_valid && (state_reg == S_ARMED || state_reg == S_POST);
        do_arm     = arm && (state_reg == S_IDLE || state_reg == S_DONE);
        do_read    = (state_reg == S_DONE) && bus.rd_en && !arm && (count_reg != '0);
        enter_done = (state_next == S_DONE) && (state_reg != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg       <= '0;
            count_reg        <= '0;
            post_cnt_reg     <= '0;
            post_written_reg <= '0;
            post_count_reg   <= '0;
            mode_reg         <= 1'b0;
            triggered_reg    <= 1'b0;
            trig_index_reg   <= '0;
            rd_valid_reg     <= 1'b0;
        end else begin
            rd_valid_reg <= do_read;
            if (do_arm) begin
                wr_ptr_reg       <= '0;
                count_reg        <= '0;
                post_cnt_reg     <= '0;
                post_written_reg <= '0;
                triggered_reg    <= 1'b0;
                trig_index_reg   <= '0;
                mode_reg         <= mode;
                post_count_reg   <= post_count;
            end else begin
                if (do_write) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    count_reg  <= count_inc;
                    if (state_reg == S_POST) begin
                        post_cnt_reg     <= post_cnt_reg - 1'b1;
                        post_written_reg <= post_written_inc;
                    end
                end
                if (state_reg == S_ARMED && !mode_reg && trig_hit) begin
                    triggered_reg <= 1'b1;
                    post_cnt_reg  <= post_count_reg;
                end
                // Offset of the trigger sample from the oldest entry still stored.
                if (enter_done)
                    trig_index_reg <= mode_reg ? '0 : count_inc[AW-1:0] - AW'(1) - post_written_inc;
                if (do_read)
                    count_reg <= count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write && !rst) mem[wr_ptr_reg] <= bus.probe_data;
        if (rst)          rd_data_reg <= '0;
        else if (do_read) rd_data_reg <= mem[rd_addr];
    end

    assign bus.rd_data  = rd_data_reg;
    assign bus.rd_valid = rd_valid_reg;
    assign state        = state_reg;
    assign count        = count_reg;
    assign trig_index   = trig_index_reg;
    assign triggered    = triggered_reg;
endmodule
